// File: rtl/fdiv_share_arbiter_if.sv
// Bundle between the FP issue ports, the shared div/sqrt unit and writeback.
// FDIV_ARB_PERF_EN adds the two performance counter outputs.
interface fdiv_share_arbiter_if #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned XLEN       = 32,
  parameter int unsigned ROB_WIDTH  = 6,
  parameter int unsigned PREG_WIDTH = 7
);
  localparam int unsigned SRC_W = $clog2(NUM_REQ);

  logic [2:0]                   frm;
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ-1:0]           req_div;
  logic [NUM_REQ*3-1:0]         req_rm;
  logic [NUM_REQ*XLEN-1:0]      req_rs1;
  logic [NUM_REQ*XLEN-1:0]      req_rs2;
  logic [NUM_REQ*ROB_WIDTH-1:0] req_rob_idx;
  logic [NUM_REQ*PREG_WIDTH-1:0] req_rd;
  logic                         redirect;
  logic [ROB_WIDTH-1:0]         redirect_idx;
  logic                         unit_div_start;
  logic                         unit_sqrt_start;
  logic [XLEN-1:0]              unit_a;
  logic [XLEN-1:0]              unit_b;
  logic [2:0]                   unit_rm;
  logic                         unit_kill;
  logic                         unit_done;
  logic [XLEN-1:0]              unit_res;
  logic [4:0]                   unit_fflags;
  logic                         wb_valid;
  logic                         wb_ready;
  logic [XLEN-1:0]              wb_res;
  logic [4:0]                   wb_fflags;
  logic [PREG_WIDTH-1:0]        wb_rd;
  logic [ROB_WIDTH-1:0]         wb_rob_idx;
  logic [SRC_W-1:0]             wb_src;
  logic                         busy;
`ifdef FDIV_ARB_PERF_EN
  logic [31:0]                  perf_busy_cnt;
  logic [31:0]                  perf_conflict_cnt;
`endif

  // Arbiter view
  modport slave (
    input  frm, req_valid, req_div, req_rm, req_rs1, req_rs2, req_rob_idx, req_rd,
    input  redirect, redirect_idx, unit_done, unit_res, unit_fflags, wb_ready,
    output req_ready, unit_div_start, unit_sqrt_start, unit_a, unit_b, unit_rm,
    output unit_kill, wb_valid, wb_res, wb_fflags, wb_rd, wb_rob_idx, wb_src,
    output busy
`ifdef FDIV_ARB_PERF_EN
    , output perf_busy_cnt, perf_conflict_cnt
`endif
  );

  // Environment view (issue queues, unit, writeback)
  modport master (
    output frm, req_valid, req_div, req_rm, req_rs1, req_rs2, req_rob_idx, req_rd,
    output redirect, redirect_idx, unit_done, unit_res, unit_fflags, wb_ready,
    input  req_ready, unit_div_start, unit_sqrt_start, unit_a, unit_b, unit_rm,
    input  unit_kill, wb_valid, wb_res, wb_fflags, wb_rd, wb_rob_idx, wb_src,
    input  busy
`ifdef FDIV_ARB_PERF_EN
    , input perf_busy_cnt, perf_conflict_cnt
`endif
  );
endinterface

// File: rtl/fdiv_share_arbiter.sv
// Round-robin sharing of one iterative FP div/sqrt unit between NUM_REQ issue ports.
// Optional FDIV_ARB_PERF_EN adds saturating busy/conflict performance counters.
module fdiv_share_arbiter #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned XLEN       = 32,
  parameter int unsigned ROB_WIDTH  = 6,
  parameter int unsigned PREG_WIDTH = 7
) (
  input  logic                clk,
  input  logic                rst,
  fdiv_share_arbiter_if.slave io
);
  localparam int unsigned SRC_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY, S_RESP} state_e;

  state_e                  state_q, state_d;
  logic [SRC_W-1:0]        rr_q, rr_d;
  logic [XLEN-1:0]         a_q, b_q, res_q;
  logic [2:0]              rm_q;
  logic                    div_q;
  logic [ROB_WIDTH-1:0]    rob_q;
  logic [PREG_WIDTH-1:0]   rd_q;
  logic [SRC_W-1:0]        src_q;
  logic [4:0]              fflags_q;

  logic [2:0]              rm_arr  [NUM_REQ];
  logic [XLEN-1:0]         rs1_arr [NUM_REQ];
  logic [XLEN-1:0]         rs2_arr [NUM_REQ];
  logic [ROB_WIDTH-1:0]    rob_arr [NUM_REQ];
  logic [PREG_WIDTH-1:0]   rd_arr  [NUM_REQ];
  logic [NUM_REQ-1:0]      req_flush;

  logic                    grant_vld;
  logic [SRC_W-1:0]        grant_idx;
  logic [SRC_W:0]          cand_sum;
  logic [SRC_W-1:0]        cand;
  logic                    op_flush;
  logic                    accept;
  logic                    capture;
  logic [NUM_REQ-1:0]      req_ready;
  logic                    div_start, sqrt_start, kill, wb_valid;
  logic [2:0]              rm_sel;

  function automatic logic is_older(input logic [ROB_WIDTH-1:0] a,
                                    input logic [ROB_WIDTH-1:0] b);
    logic same_flag;
    same_flag = (a[ROB_WIDTH-1] == b[ROB_WIDTH-1]);
    return same_flag ? (a[ROB_WIDTH-2:0] < b[ROB_WIDTH-2:0])
                     : (a[ROB_WIDTH-2:0] > b[ROB_WIDTH-2:0]);
  endfunction

  // Equal robIdx counts as flushed since it is not strictly older
  function automatic logic is_flushed(input logic [ROB_WIDTH-1:0] r,
                                      input logic redir,
                                      input logic [ROB_WIDTH-1:0] ridx);
    return redir && !is_older(r, ridx);
  endfunction

  // Unpack the flat request buses per port
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      rm_arr[k]    = io.req_rm[k*3 +: 3];
      rs1_arr[k]   = io.req_rs1[k*XLEN +: XLEN];
      rs2_arr[k]   = io.req_rs2[k*XLEN +: XLEN];
      rob_arr[k]   = io.req_rob_idx[k*ROB_WIDTH +: ROB_WIDTH];
      rd_arr[k]    = io.req_rd[k*PREG_WIDTH +: PREG_WIDTH];
      req_flush[k] = is_flushed(rob_arr[k], io.redirect, io.redirect_idx);
    end
  end

  // Round-robin search starting at rr_q, skipping flushed requests
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand_sum  = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_sum = (SRC_W+1)'(rr_q) + (SRC_W+1)'(k);
      cand = (cand_sum >= (SRC_W+1)'(NUM_REQ)) ? SRC_W'(cand_sum - (SRC_W+1)'(NUM_REQ))
                                                : SRC_W'(cand_sum);
      if (!grant_vld && io.req_valid[cand] && !req_flush[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    req_ready  = '0;
    accept     = 1'b0;
    capture    = 1'b0;
    div_start  = 1'b0;
    sqrt_start = 1'b0;
    kill       = 1'b0;
    wb_valid   = 1'b0;
    op_flush   = is_flushed(rob_q, io.redirect, io.redirect_idx);
    unique case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          req_ready = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx;
          accept    = 1'b1;
          rr_d      = (grant_idx == SRC_W'(NUM_REQ-1)) ? '0 : grant_idx + SRC_W'(1);
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (op_flush) begin
          state_d = S_IDLE;
        end else begin
          div_start  = div_q;
          sqrt_start = !div_q;
          state_d    = S_BUSY;
        end
      end
      S_BUSY: begin
        // A flush wins over a simultaneous done; that result is dropped
        if (op_flush) begin
          kill    = 1'b1;
          state_d = S_IDLE;
        end else if (io.unit_done) begin
          capture = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (op_flush) begin
          state_d = S_IDLE;
        end else begin
          wb_valid = 1'b1;
          if (io.wb_ready) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (!rst) begin
      req_ready  = '0;
      accept     = 1'b0;
      capture    = 1'b0;
      div_start  = 1'b0;
      sqrt_start = 1'b0;
      kill       = 1'b0;
      wb_valid   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
    end
  end

  assign rm_sel = rm_arr[grant_idx];

  // Operand/result holding registers, intentionally without reset
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q   <= rs1_arr[grant_idx];
      b_q   <= rs2_arr[grant_idx];
      div_q <= io.req_div[grant_idx];
      rm_q  <= (rm_sel == 3'b111) ? io.frm : rm_sel;
      rob_q <= rob_arr[grant_idx];
      rd_q  <= rd_arr[grant_idx];
      src_q <= grant_idx;
    end
    if (capture) begin
      res_q    <= io.unit_res;
      fflags_q <= io.unit_fflags;
    end
  end

  assign io.req_ready       = req_ready;
  assign io.unit_div_start  = div_start;
  assign io.unit_sqrt_start = sqrt_start;
  assign io.unit_a          = a_q;
  assign io.unit_b          = b_q;
  assign io.unit_rm         = rm_q;
  assign io.unit_kill       = kill;
  assign io.wb_valid        = wb_valid;
  assign io.wb_res          = res_q;
  assign io.wb_fflags       = fflags_q;
  assign io.wb_rd           = rd_q;
  assign io.wb_rob_idx      = rob_q;
  assign io.wb_src          = src_q;
  assign io.busy            = (state_q != S_IDLE);

`ifdef FDIV_ARB_PERF_EN
  logic [31:0] perf_busy_q;
  logic [31:0] perf_conf_q;

  // Saturating utilisation and contention counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_busy_q <= '0;
      perf_conf_q <= '0;
    end else begin
      if ((state_q != S_IDLE) && !(&perf_busy_q)) perf_busy_q <= perf_busy_q + 32'd1;
      if ((|(io.req_valid & ~req_ready)) && !(&perf_conf_q)) perf_conf_q <= perf_conf_q + 32'd1;
    end
  end

  assign io.perf_busy_cnt     = perf_busy_q;
  assign io.perf_conflict_cnt = perf_conf_q;
`else
  // Counters and their ports are absent in this build
`endif

endmodule
